// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_pkg
// Description : Shared defaults, register count and FSM state type for the
//               reg_bank_resp register bank responder.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

    localparam int c_DATA_W = 6;
    localparam int c_ADDR_W = 3;
    localparam int c_NREGS  = 2 ** c_ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_bank_array.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_array
// Description : NREGS x DATA_W register storage, one write and one read port,
//               reset to reg[i] = i. Optional macro REG_BANK_PARITY_EN adds an
//               even-parity bit per register and a read parity-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_array
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
`ifdef REG_BANK_PARITY_EN
    ,
    output logic              rperr
`endif
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge ck) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= DATA_W'(i);
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

`ifdef REG_BANK_PARITY_EN
    // Stored bit makes data+parity carry an even number of ones.
    logic [NREGS-1:0] r_par;

    always_ff @(posedge ck) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_par[i] <= ^(DATA_W'(i));
            end
        end else if (we) begin
            r_par[waddr] <= ^wdata;
        end
    end

    assign rperr = (^r_mem[raddr]) ^ r_par[raddr];
`endif

endmodule
`default_nettype wire

// File: rtl/reg_bank_resp.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_resp
// Description : Four-phase req/ack register bank responder (IDLE/ACCESS/HOLD).
//               Optional macro REG_BANK_PARITY_EN adds parity and perr port.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_resp
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy
`ifdef REG_BANK_PARITY_EN
    ,
    output logic              perr
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic              w_cap;
    logic              w_access;
    logic              w_release;

    logic              r_we_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_wdata_q;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ack;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_rdata;

    always_ff @(posedge ck) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cap     = 1'b0;
        w_access  = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_cap  = 1'b1;
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                w_access = 1'b1;
                w_next   = HOLD;
            end
            HOLD: begin
                if (!req) begin
                    w_release = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Request fields are frozen at capture; later bus changes are ignored.
    always_ff @(posedge ck) begin
        if (!rst) begin
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_rdata   <= '0;
            r_ack     <= 1'b0;
        end else begin
            if (w_cap) begin
                r_we_q    <= we;
                r_addr_q  <= addr;
                r_wdata_q <= wdata;
            end
            if (w_access) begin
                r_ack <= 1'b1;
                if (!r_we_q) begin
                    r_rdata <= w_mem_rdata;
                end
            end
            if (w_release) begin
                r_ack <= 1'b0;
            end
        end
    end

    assign w_mem_we = w_access & r_we_q;
    assign rdata    = r_rdata;
    assign ack      = r_ack;
    assign busy     = (r_state != IDLE);

`ifdef REG_BANK_PARITY_EN
    logic w_mem_perr;
    logic r_perr;

    always_ff @(posedge ck) begin
        if (!rst) begin
            r_perr <= 1'b0;
        end else if (w_access) begin
            r_perr <= ~r_we_q & w_mem_perr;
        end else if (w_release) begin
            r_perr <= 1'b0;
        end
    end

    assign perr = r_perr;
`endif

    reg_bank_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .ck    (ck),
        .rst   (rst),
        .we    (w_mem_we),
        .waddr (r_addr_q),
        .wdata (r_wdata_q),
        .raddr (r_addr_q),
        .rdata (w_mem_rdata)
`ifdef REG_BANK_PARITY_EN
        ,
        .rperr (w_mem_perr)
`endif
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_resp
// Description : Self-checking bench for reg_bank_resp against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_resp;

    localparam int DW = 6;
    localparam int AW = 3;
    localparam int NR = 8;

    logic          ck = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          busy;
`ifdef REG_BANK_PARITY_EN
    logic          perr;
`endif

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] model [NR];
    logic [DW-1:0] model_rd;
    logic          exp_perr = 1'b0;

    reg_bank_resp #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .ck    (ck),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .busy  (busy)
`ifdef REG_BANK_PARITY_EN
        ,
        .perr  (perr)
`endif
    );

    always #5 ck = ~ck;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset;
        for (int i = 0; i < NR; i++) model[i] = DW'(i);
        model_rd = '0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic txn(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int hold);
        int cycles;
        req = 1'b1; we = w; addr = a; wdata = d;
        cycles = 0;
        do begin
            @(negedge ck);
            cycles++;
            if (ack !== 1'b1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_in_txn: got %b want 1", busy);
                end
            end
        end while (ack !== 1'b1 && cycles < 6);
        checks++;
        if (ack !== 1'b1 || cycles != 2) begin
            errors++;
            $display("FAIL ack_latency: ack=%b after %0d edges, want 1 after 2", ack, cycles);
        end
        if (w) model[a] = d;
        else   model_rd = model[a];
        checks++;
        if (rdata !== model_rd) begin
            errors++;
            $display("FAIL rdata(we=%b addr=%0d): got %h want %h", w, a, rdata, model_rd);
        end
`ifdef REG_BANK_PARITY_EN
        checks++;
        if (perr !== exp_perr) begin
            errors++;
            $display("FAIL perr_with_ack: got %b want %b", perr, exp_perr);
        end
`endif
        we = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
        for (int k = 0; k < hold; k++) begin
            @(negedge ck);
            checks++;
            if (ack !== 1'b1 || rdata !== model_rd) begin
                errors++;
                $display("FAIL hold_stable: ack=%b rdata=%h want ack=1 rdata=%h", ack, rdata, model_rd);
            end
        end
        req = 1'b0;
        @(negedge ck);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release: ack=%b busy=%b want 0 0", ack, busy);
        end
`ifdef REG_BANK_PARITY_EN
        checks++;
        if (perr !== 1'b0) begin
            errors++;
            $display("FAIL perr_clear: got %b want 0", perr);
        end
`endif
    endtask

    task automatic apply_reset;
        rst = 1'b0; req = 1'b1; we = 1'b1;
        addr = AW'($urandom); wdata = DW'($urandom);
        repeat (3) @(negedge ck);
        rst = 1'b1; req = 1'b0; we = 1'b0;
        model_reset();
        @(negedge ck);
    endtask

    task automatic test_reset;
        rst = 1'b0; req = 1'b1; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge ck);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b busy=%b rdata=%h want 0 0 00", ack, busy, rdata);
        end
        rst = 1'b1; req = 1'b0;
        model_reset();
        @(negedge ck);
        txn(1'b0, 3'd3, '0, 0);
        checks++;
        if (rdata !== 6'd3) begin
            errors++;
            $display("FAIL reset_read3: got %h want 03", rdata);
        end
        for (int i = 0; i < NR; i++) txn(1'b0, AW'(i), '0, 0);
    endtask

    task automatic test_write_read;
        txn(1'b1, 3'd2, 6'h2A, 0);
        txn(1'b0, 3'd2, '0, 1);
        checks++;
        if (rdata !== 6'h2A) begin
            errors++;
            $display("FAIL write_read2: got %h want 2a", rdata);
        end
    endtask

    task automatic test_hold;
        txn(1'b0, 3'd6, '0, 5);
        txn(1'b1, 3'd6, 6'h11, 5);
    endtask

    task automatic test_swap;
        logic [DW-1:0] v;
        apply_reset();
        txn(1'b0, 3'd3, '0, 0); v = rdata; txn(1'b1, 3'd2, v, 0);
        txn(1'b0, 3'd4, '0, 0); v = rdata; txn(1'b1, 3'd3, v, 0);
        txn(1'b0, 3'd2, '0, 0); v = rdata; txn(1'b1, 3'd4, v, 0);
        txn(1'b0, 3'd2, '0, 0);
        checks++;
        if (rdata !== 6'd3) begin errors++; $display("FAIL swap_reg2: got %h want 03", rdata); end
        txn(1'b0, 3'd3, '0, 0);
        checks++;
        if (rdata !== 6'd4) begin errors++; $display("FAIL swap_reg3: got %h want 04", rdata); end
        txn(1'b0, 3'd4, '0, 0);
        checks++;
        if (rdata !== 6'd3) begin errors++; $display("FAIL swap_reg4: got %h want 03", rdata); end
    endtask

    task automatic test_reset_mid;
        req = 1'b1; we = 1'b1; addr = 3'd5; wdata = 6'h3F;
        @(negedge ck);
        rst = 1'b0;
        @(negedge ck);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_mid: ack=%b busy=%b rdata=%h want 0 0 00", ack, busy, rdata);
        end
        rst = 1'b1; req = 1'b0; we = 1'b0;
        model_reset();
        @(negedge ck);
        txn(1'b0, 3'd5, '0, 0);
        checks++;
        if (rdata !== 6'd5) begin
            errors++;
            $display("FAIL reset_mid_reg5: got %h want 05", rdata);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            txn(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(2, 0)));
        end
        for (int i = 0; i < NR; i++) txn(1'b0, AW'(i), '0, 0);
    endtask

    task automatic test_parity;
        apply_reset();
`ifdef REG_BANK_PARITY_EN
        force dut.u_array.r_par[1] = 1'b0;
        exp_perr = 1'b1;
        txn(1'b0, 3'd1, '0, 0);
        release dut.u_array.r_par[1];
        exp_perr = 1'b0;
        apply_reset();
        txn(1'b0, 3'd1, '0, 0);
`else
        txn(1'b0, 3'd1, '0, 0);
        checks++;
        if (rdata !== 6'd1) begin
            errors++;
            $display("FAIL parity_off_read1: got %h want 01", rdata);
        end
`endif
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        model_reset();
        @(negedge ck);
        test_reset();
        test_write_read();
        test_hold();
        test_reset_mid();
        test_random();
        test_swap();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
